// File: rtl/test_engine_arbiter_pkg.sv
// rtl/test_engine_arbiter_pkg.sv - shared state encoding and widths for the test engine arbiter
package test_engine_arbiter_pkg;

    localparam int WORD_WIDTH             = 64;
    localparam int DEFAULT_TIMEOUT_CYCLES = 256;

    localparam logic [1:0] ST_IDLE_ENC    = 2'd0;
    localparam logic [1:0] ST_ISSUE_ENC   = 2'd1;
    localparam logic [1:0] ST_WAIT_ENC    = 2'd2;
    localparam logic [1:0] ST_DELIVER_ENC = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE    = ST_IDLE_ENC,
        ST_ISSUE   = ST_ISSUE_ENC,
        ST_WAIT    = ST_WAIT_ENC,
        ST_DELIVER = ST_DELIVER_ENC
    } state_t;

endpackage

// File: rtl/test_engine_arbiter_rr.sv
// rtl/test_engine_arbiter_rr.sv - two-way round-robin grant with registered priority pointer
module round_robin_arbiter2
    import test_engine_arbiter_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req_i,
    input  logic       grant_en_i,
    output logic       grant_valid_o,
    output logic       grant_idx_o
);

    logic ptr_q;

    always_comb begin
        grant_valid_o = |req_i;
        grant_idx_o   = 1'b0;
        if (req_i[0] && req_i[1]) begin
            grant_idx_o = ptr_q;
        end else if (req_i[1]) begin
            grant_idx_o = 1'b1;
        end
    end

    // Pointer always moves to the side that just lost priority.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_q <= 1'b0;
        end else if (grant_en_i && grant_valid_o) begin
            ptr_q <= ~grant_idx_o;
        end
    end

endmodule

// File: rtl/test_engine_arbiter.sv
// rtl/test_engine_arbiter.sv - shares one test engine between two requesters with a watchdog
module test_engine_arbiter
    import test_engine_arbiter_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req0_din,
    input  logic                  req1_din,
    input  logic [WORD_WIDTH-1:0] wordA0_din,
    input  logic [WORD_WIDTH-1:0] wordB0_din,
    input  logic [WORD_WIDTH-1:0] wordA1_din,
    input  logic [WORD_WIDTH-1:0] wordB1_din,
    output logic                  done0_dout,
    output logic                  done1_dout,
    output logic                  timeout_dout,
    output logic [WORD_WIDTH-1:0] wordC_dout,
    output logic [WORD_WIDTH-1:0] wordD_dout,
    output logic                  busy_dout,
    output logic                  engine_start_dout,
    output logic [WORD_WIDTH-1:0] engine_wordA_dout,
    output logic [WORD_WIDTH-1:0] engine_wordB_dout,
    input  logic                  engine_done_din,
    input  logic                  engine_active_din,
    input  logic [WORD_WIDTH-1:0] engine_wordC_din,
    input  logic [WORD_WIDTH-1:0] engine_wordD_din
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t                  state_q;
    logic                    grant_idx_q;
    logic [CNT_W-1:0]        cnt_q;
    logic [CNT_W-1:0]        cnt_d;
    logic                    start_q;
    logic                    busy_q;
    logic                    done0_q;
    logic                    done1_q;
    logic                    timeout_q;
    logic [WORD_WIDTH-1:0]   word_a_q;
    logic [WORD_WIDTH-1:0]   word_b_q;
    logic [WORD_WIDTH-1:0]   word_c_q;
    logic [WORD_WIDTH-1:0]   word_d_q;

    logic                    grant_en;
    logic                    grant_valid;
    logic                    grant_idx;

    assign grant_en = (state_q == ST_IDLE) && !engine_active_din;
    assign cnt_d    = cnt_q + 1'b1;

    round_robin_arbiter2 u_rr (
        .clk           (clk),
        .reset         (reset),
        .req_i         ({req1_din, req0_din}),
        .grant_en_i    (grant_en),
        .grant_valid_o (grant_valid),
        .grant_idx_o   (grant_idx)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            grant_idx_q <= 1'b0;
            cnt_q       <= '0;
            start_q     <= 1'b0;
            busy_q      <= 1'b0;
            done0_q     <= 1'b0;
            done1_q     <= 1'b0;
            timeout_q   <= 1'b0;
            word_a_q    <= '0;
            word_b_q    <= '0;
            word_c_q    <= '0;
            word_d_q    <= '0;
        end else begin
            start_q   <= 1'b0;
            done0_q   <= 1'b0;
            done1_q   <= 1'b0;
            timeout_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (grant_en && grant_valid) begin
                        grant_idx_q <= grant_idx;
                        word_a_q    <= grant_idx ? wordA1_din : wordA0_din;
                        word_b_q    <= grant_idx ? wordB1_din : wordB0_din;
                        start_q     <= 1'b1;
                        busy_q      <= 1'b1;
                        state_q     <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    cnt_q   <= '0;
                    state_q <= ST_WAIT;
                end
                ST_WAIT: begin
                    // A real engine done wins over a watchdog expiry on the same edge.
                    if (engine_done_din) begin
                        word_c_q <= engine_wordC_din;
                        word_d_q <= engine_wordD_din;
                        done0_q  <= ~grant_idx_q;
                        done1_q  <= grant_idx_q;
                        state_q  <= ST_DELIVER;
                    end else begin
                        cnt_q <= cnt_d;
                        if (cnt_d == CNT_LAST) begin
                            word_c_q  <= '0;
                            word_d_q  <= '0;
                            timeout_q <= 1'b1;
                            done0_q   <= ~grant_idx_q;
                            done1_q   <= grant_idx_q;
                            state_q   <= ST_DELIVER;
                        end
                    end
                end
                ST_DELIVER: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign done0_dout        = done0_q;
    assign done1_dout        = done1_q;
    assign timeout_dout      = timeout_q;
    assign wordC_dout        = word_c_q;
    assign wordD_dout        = word_d_q;
    assign busy_dout         = busy_q;
    assign engine_start_dout = start_q;
    assign engine_wordA_dout = word_a_q;
    assign engine_wordB_dout = word_b_q;

endmodule
